// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies,
// FSM state encoding and a two's-complement helper.
package mdu_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MTHI  = 4'd4;
    localparam logic [3:0] MDU_MTLO  = 4'd5;
    localparam logic [3:0] MDU_MADD  = 4'd6;
    localparam logic [3:0] MDU_MADDU = 4'd7;
    localparam logic [3:0] MDU_MSUB  = 4'd8;
    localparam logic [3:0] MDU_MSUBU = 4'd9;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;
    localparam int MDU_CNT_W           = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit holding HI/LO with fixed multi-cycle latencies.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e           state_q;
    logic [MDU_CNT_W-1:0] cnt_q;
    logic                 busy_q;
    logic [31:0]          hi_q, lo_q, p_hi_q, p_lo_q;
    logic                 p_wr_q;

    logic                 fin_s, accept_s, is_long_s, wr_d, mthi_s, mtlo_s;
    logic [MDU_CNT_W-1:0] cnt_d;
    logic [63:0]          res_d, prod_s_s, prod_u_s;
    logic [31:0]          div_b_s, abs_a_s, abs_b_s, qs_mag_s, rs_mag_s;
    logic [31:0]          q_s_s, r_s_s, q_u_s, r_u_s;
`ifdef MDU_MADD_EN
    logic [63:0]          base_s;
`endif

    // Arithmetic datapath and op decode, evaluated against the current request
    always_comb begin
        fin_s    = (state_q == ST_BUSY) && (cnt_q == MDU_CNT_W'(1));
        accept_s = start && ((state_q == ST_IDLE) || fin_s);

        prod_s_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        prod_u_s = {32'd0, a} * {32'd0, b};

        // A zero divisor is replaced so the dividers never see it; the result is discarded anyway
        div_b_s  = (b == 32'd0) ? 32'd1 : b;
        abs_a_s  = a[31] ? neg32(a) : a;
        abs_b_s  = div_b_s[31] ? neg32(div_b_s) : div_b_s;
        qs_mag_s = abs_a_s / abs_b_s;
        rs_mag_s = abs_a_s % abs_b_s;
        q_s_s    = (a[31] ^ div_b_s[31]) ? neg32(qs_mag_s) : qs_mag_s;
        r_s_s    = a[31] ? neg32(rs_mag_s) : rs_mag_s;
        q_u_s    = a / div_b_s;
        r_u_s    = a % div_b_s;

`ifdef MDU_MADD_EN
        // Accumulate onto the value HI/LO will hold after this edge (covers back-to-back issue)
        base_s   = (fin_s && p_wr_q) ? {p_hi_q, p_lo_q} : {hi_q, lo_q};
`endif

        is_long_s = 1'b0;
        wr_d      = 1'b0;
        mthi_s    = 1'b0;
        mtlo_s    = 1'b0;
        cnt_d     = MDU_CNT_W'(MULT_CYCLES);
        res_d     = 64'd0;
        case (op)
            MDU_MULT:  begin is_long_s = 1'b1; wr_d = 1'b1; res_d = prod_s_s; end
            MDU_MULTU: begin is_long_s = 1'b1; wr_d = 1'b1; res_d = prod_u_s; end
            MDU_DIV: begin
                is_long_s = 1'b1;
                wr_d      = (b != 32'd0);
                cnt_d     = MDU_CNT_W'(DIV_CYCLES);
                res_d     = {r_s_s, q_s_s};
            end
            MDU_DIVU: begin
                is_long_s = 1'b1;
                wr_d      = (b != 32'd0);
                cnt_d     = MDU_CNT_W'(DIV_CYCLES);
                res_d     = {r_u_s, q_u_s};
            end
            MDU_MTHI:  mthi_s = 1'b1;
            MDU_MTLO:  mtlo_s = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin is_long_s = 1'b1; wr_d = 1'b1; res_d = base_s + prod_s_s; end
            MDU_MADDU: begin is_long_s = 1'b1; wr_d = 1'b1; res_d = base_s + prod_u_s; end
            MDU_MSUB:  begin is_long_s = 1'b1; wr_d = 1'b1; res_d = base_s - prod_s_s; end
            MDU_MSUBU: begin is_long_s = 1'b1; wr_d = 1'b1; res_d = base_s - prod_u_s; end
`endif
            default: begin
                is_long_s = 1'b0;
                wr_d      = 1'b0;
            end
        endcase
    end

    // FSM, latency counter, pending result and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            p_wr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_BUSY: begin
                    cnt_q <= cnt_q - MDU_CNT_W'(1);
                    if (fin_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (p_wr_q) begin
                            hi_q <= p_hi_q;
                            lo_q <= p_lo_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Placed after the commit so a request at the completion edge overrides it
            if (accept_s) begin
                if (is_long_s) begin
                    state_q <= ST_BUSY;
                    busy_q  <= 1'b1;
                    cnt_q   <= cnt_d;
                    p_hi_q  <= res_d[63:32];
                    p_lo_q  <= res_d[31:0];
                    p_wr_q  <= wr_d;
                end else if (mthi_s) begin
                    hi_q <= a;
                end else if (mtlo_s) begin
                    lo_q <= a;
                end
            end
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Table-driven self-checking bench for mdu plus hand sequences for
// MTHI, asynchronous reset mid-operation and back-to-back issue.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          exp_cyc;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_busy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'd0,    32'd0,    32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,    32'd0,    32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'd0,    32'd0,    32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{4'd3, 32'd100,      32'd0,        32'd5,    32'd6,    32'd5,        32'd6,        10};
        vecs[4]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd9,    32'd9,    32'd0,        32'h80000000, 10};
        vecs[5]  = '{4'd3, 32'hFFFFFFFF, 32'd10,       32'd0,    32'd0,    32'd5,        32'h19999999, 10};
        vecs[6]  = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd0,    32'd0,    32'd1,        32'hFFFFFFFD, 10};
        vecs[7]  = '{4'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0,    32'd0,    32'h3FFFFFFF, 32'h00000001, 5};
        vecs[8]  = '{4'd0, 32'h80000000, 32'h80000000, 32'd0,    32'd0,    32'h40000000, 32'h00000000, 5};
        vecs[9]  = '{4'd10, 32'd1,       32'd1,        32'h11,   32'h22,   32'h11,       32'h22,       0};
        vecs[10] = '{4'd2, 32'd50,       32'd0,        32'hAA,   32'hBB,   32'hAA,       32'hBB,       10};
`ifdef MDU_MADD_EN
        vecs[11] = '{4'd7, 32'd1,        32'd1,        32'd0,    32'hFFFFFFFF, 32'd1,    32'd0,        5};
        vecs[12] = '{4'd8, 32'd1,        32'd1,        32'd0,    32'd0,    32'hFFFFFFFF, 32'hFFFFFFFF, 5};
`else
        vecs[11] = '{4'd7, 32'd1,        32'd1,        32'd0,    32'hFFFFFFFF, 32'd0,    32'hFFFFFFFF, 0};
        vecs[12] = '{4'd8, 32'd1,        32'd1,        32'd0,    32'd0,    32'd0,        32'd0,        0};
`endif

        reset = 1'b0; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(4'd4, vecs[i].pre_hi, 32'd0);
            issue(4'd5, vecs[i].pre_lo, 32'd0);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_busy(cyc);
            chk($sformatf("vec%0d cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            chk($sformatf("vec%0d lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
        end

        // MTHI: immediate write, LO untouched, never busy
        issue(4'd5, 32'h55, 32'd0);
        issue(4'd4, 32'h12345678, 32'd0);
        chk("mthi hi", {32'd0, hi}, 64'h12345678);
        chk("mthi lo", {32'd0, lo}, 64'h55);
        chk("mthi busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk("mthi busy later", {63'd0, busy}, 64'd0);

        // Reset during busy cycle 4 of a DIV
        issue(4'd4, 32'hAAAA, 32'd0);
        issue(4'd5, 32'hBBBB, 32'd0);
        issue(4'd2, 32'd7, 32'd2);
        repeat (3) @(posedge clk);
        #3;
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("async busy", {63'd0, busy}, 64'd0);
        chk("async hi", {32'd0, hi}, 64'd0);
        chk("async lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post-reset busy", {63'd0, busy}, 64'd0);
        chk("post-reset hi", {32'd0, hi}, 64'd0);
        chk("post-reset lo", {32'd0, lo}, 64'd0);

        // Back-to-back: second start at the completion edge of the first
        issue(4'd0, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b busy before", {63'd0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 32'd4; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b busy no gap", {63'd0, busy}, 64'd1);
        chk("b2b first lo", {32'd0, lo}, 64'd6);
        wait_busy(cyc);
        chk("b2b cycles", 64'(cyc), 64'd5);
        chk("b2b second lo", {32'd0, lo}, 64'd20);
        chk("b2b second hi", {32'd0, hi}, 64'd0);

        // Start while busy is ignored
        issue(4'd1, 32'd3, 32'd3);
        issue(4'd4, 32'hDEAD, 32'd0);
        wait_busy(cyc);
        chk("ignored cycles", 64'(cyc), 64'd4);
        chk("ignored hi", {32'd0, hi}, 64'd0);
        chk("ignored lo", {32'd0, lo}, 64'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
